fall_sched: RTL

- Scheduler/controller for the falling-object game datapath on the 8x8 LED matrix.
- Owns up to N_OBJ falling-object slots and the LFSR that picks spawn columns and object kinds.
- Steps all objects on each move tick and detects collisions with the player column.
- Maintains lives and the IDLE/PLAY/OVER game FSM.
- Downstream matrix scan and 7-segment logic consume its outputs; it does not drive the display itself.

---
 rtl/fall_pkg.sv | 30 +++
 rtl/fall_sched_lfsr8.sv | 29 ++
 rtl/fall_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fall_pkg.sv
// Shared types and constants for the falling-object game scheduler.
package fall_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  // One falling-object slot.
  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
    logic       kind;
  } obj_t;

  localparam logic [7:0] LFSR_MASK   = 8'hB8;
  localparam logic [2:0] ROW_PLAYER  = 3'd7;
  localparam logic       KIND_HAZARD = 1'b0;
  localparam logic       KIND_BONUS  = 1'b1;
  localparam logic [1:0] LIVES_MAX   = 2'd3;
  localparam obj_t       OBJ_EMPTY   = '0;

  // Galois right-shift step of the spawn LFSR.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 8'h00);
  endfunction

endpackage

// File: rtl/fall_sched_lfsr8.sv
// 8-bit LFSR that supplies spawn columns and object kinds.
module lfsr8
  import fall_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Advance only when the scheduler consumes a game tick.
  always_comb begin
    lfsr_d = en_i ? lfsr_next(lfsr_q) : lfsr_q;
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/fall_sched.sv
// Falling-object game scheduler: object slots, collisions, lives and game FSM.
// Handshake: none; step_tick is a one-cycle strobe, effects appear one cycle later.
module fall_sched
  import fall_pkg::*;
#(
  parameter int         N_OBJ      = 4,
  parameter int         SPAWN_GAP  = 2,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         LIVES_INIT = 3
) (
  input  logic                 CLK,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 step_tick,
  input  logic [2:0]           player_col,
  output logic [N_OBJ-1:0]     obj_valid,
  output logic [3*N_OBJ-1:0]   obj_col,
  output logic [3*N_OBJ-1:0]   obj_row,
  output logic [N_OBJ-1:0]     obj_kind,
  output logic [1:0]           lives,
  output logic                 hit_pulse,
  output logic                 bonus_pulse,
  output logic                 game_over,
  output logic [1:0]           state
);

  localparam int            GW         = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(SPAWN_GAP - 1);

  state_e        state_q, state_d;
  obj_t          slots_q [N_OBJ];
  obj_t          slots_d [N_OBJ];
  logic [1:0]    lives_q, lives_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          hit_q, hit_d;
  logic          bonus_q, bonus_d;
  logic          adv;
  logic          any_hazard;
  logic          any_bonus;
  logic          found;
  logic [7:0]    lfsr;
  logic          unused_lfsr_bits;

  assign unused_lfsr_bits = ^lfsr[4:3];

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i (CLK),
    .rst_i (clear),
    .en_i  (adv),
    .lfsr_o(lfsr)
  );

  // Next-state: FSM transitions and the retire/advance/collide/spawn tick pipeline.
  always_comb begin
    state_d    = state_q;
    slots_d    = slots_q;
    lives_d    = lives_q;
    gap_d      = gap_q;
    hit_d      = 1'b0;
    bonus_d    = 1'b0;
    adv        = 1'b0;
    any_hazard = 1'b0;
    any_bonus  = 1'b0;
    found      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PLAY;
          lives_d = 2'(LIVES_INIT);
          gap_d   = '0;
          for (int i = 0; i < N_OBJ; i++) slots_d[i] = OBJ_EMPTY;
        end
      end
      ST_PLAY: begin
        if (lives_q == 2'd0) begin
          state_d = ST_OVER;
          for (int i = 0; i < N_OBJ; i++) slots_d[i] = OBJ_EMPTY;
        end else if (step_tick) begin
          adv = 1'b1;
          // Objects that sat on the player row last tick leave the board.
          for (int i = 0; i < N_OBJ; i++)
            if (slots_d[i].valid && slots_d[i].row == ROW_PLAYER) slots_d[i] = OBJ_EMPTY;
          for (int i = 0; i < N_OBJ; i++)
            if (slots_d[i].valid) slots_d[i].row = slots_d[i].row + 3'd1;
          // Landing on the player consumes the object.
          for (int i = 0; i < N_OBJ; i++) begin
            if (slots_d[i].valid && slots_d[i].row == ROW_PLAYER &&
                slots_d[i].col == player_col) begin
              if (slots_d[i].kind == KIND_HAZARD) any_hazard = 1'b1;
              else                                any_bonus  = 1'b1;
              slots_d[i] = OBJ_EMPTY;
            end
          end
          if (any_hazard) begin
            hit_d = 1'b1;
            if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
          end else if (any_bonus) begin
            bonus_d = 1'b1;
            if (lives_q != LIVES_MAX) lives_d = lives_q + 2'd1;
          end
          if (gap_q == '0) begin
            for (int i = 0; i < N_OBJ; i++) begin
              if (!found && !slots_d[i].valid) begin
                found            = 1'b1;
                slots_d[i].valid = 1'b1;
                slots_d[i].row   = 3'd0;
                slots_d[i].col   = lfsr[2:0];
                slots_d[i].kind  = (lfsr[7:5] == 3'b111);
              end
            end
          end
          if (found)             gap_d = GAP_RELOAD;
          else if (gap_q != '0)  gap_d = gap_q - GW'(1);
        end
      end
      ST_OVER: begin
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (clear) begin
      state_q <= ST_IDLE;
      lives_q <= 2'd0;
      gap_q   <= '0;
      hit_q   <= 1'b0;
      bonus_q <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) slots_q[i] <= OBJ_EMPTY;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      gap_q   <= gap_d;
      hit_q   <= hit_d;
      bonus_q <= bonus_d;
      for (int i = 0; i < N_OBJ; i++) slots_q[i] <= slots_d[i];
    end
  end

  // Flatten slot registers onto the output buses.
  always_comb begin
    obj_valid = '0;
    obj_col   = '0;
    obj_row   = '0;
    obj_kind  = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      obj_valid[i]     = slots_q[i].valid;
      obj_col[3*i +: 3] = slots_q[i].col;
      obj_row[3*i +: 3] = slots_q[i].row;
      obj_kind[i]      = slots_q[i].kind;
    end
  end

  assign lives       = lives_q;
  assign hit_pulse   = hit_q;
  assign bonus_pulse = bonus_q;
  assign game_over   = (state_q == ST_OVER);
  assign state       = state_q;

endmodule
